// File: rtl/alu_op_sequencer.sv
// Issues decoded ALU ops to alu_stage one at a time. Long ops run as two carry-chained
// passes; this block owns the architectural NZCV flags.
module alu_op_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                op_valid_in,
    output logic                op_ready_out,
    input  logic [CTRL_W-1:0]   op_ctrl_in,
    input  logic [2*DATA_W-1:0] op_a_in,
    input  logic [2*DATA_W-1:0] op_b_in,
    input  logic                op_long_in,
    input  logic                op_carry_in,
    input  logic                op_clz_in,
    input  logic [3:0]          op_cond_in,
    input  logic                op_set_flags_in,
    input  logic                op_bs_upd_in,
    input  logic                op_bs_carry_in,
    output logic                alu_issue_out,
    output logic [DATA_W-1:0]   alu_a_out,
    output logic [DATA_W-1:0]   alu_b_out,
    output logic [CTRL_W-1:0]   alu_ctrl_out,
    output logic                alu_carry_out,
    output logic                alu_clz_out,
    output logic                alu_bs_upd_out,
    output logic                alu_bs_carry_out,
    input  logic [DATA_W-1:0]   alu_result_in,
    input  logic [3:0]          alu_flags_in,
    output logic                res_valid_out,
    input  logic                res_ready_in,
    output logic [2*DATA_W-1:0] res_out,
    output logic                res_skipped_out,
    output logic [3:0]          flags_out
);

    localparam int unsigned RES_W  = 2 * DATA_W;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_LO,
        S_ISSUE_HI,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [RES_W-1:0]    a_q, a_d, b_q, b_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [3:0]          cond_q, cond_d;
    logic                long_q, long_d, carry_q, carry_d, clz_q, clz_d;
    logic                set_flags_q, set_flags_d, bs_upd_q, bs_upd_d, bs_carry_q, bs_carry_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                z_lo_q, z_lo_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic                skipped_q, skipped_d;
    logic [3:0]          flags_q, flags_d;
    logic [3:0]          new_flags;

    // ARM condition check against {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d          = state_q;
        a_d              = a_q;
        b_d              = b_q;
        ctrl_d           = ctrl_q;
        cond_d           = cond_q;
        long_d           = long_q;
        carry_d          = carry_q;
        clz_d            = clz_q;
        set_flags_d      = set_flags_q;
        bs_upd_d         = bs_upd_q;
        bs_carry_d       = bs_carry_q;
        lo_d             = lo_q;
        z_lo_d           = z_lo_q;
        res_d            = res_q;
        skipped_d        = skipped_q;
        flags_d          = flags_q;
        new_flags        = alu_flags_in;
        op_ready_out     = 1'b0;
        res_valid_out    = 1'b0;
        alu_issue_out    = 1'b0;
        alu_a_out        = '0;
        alu_b_out        = '0;
        alu_ctrl_out     = '0;
        alu_carry_out    = 1'b0;
        alu_clz_out      = 1'b0;
        alu_bs_upd_out   = 1'b0;
        alu_bs_carry_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                op_ready_out = 1'b1;
                if (op_valid_in) begin
                    a_d         = op_a_in;
                    b_d         = op_b_in;
                    ctrl_d      = op_ctrl_in;
                    cond_d      = op_cond_in;
                    long_d      = op_long_in;
                    carry_d     = op_carry_in;
                    clz_d       = op_clz_in;
                    set_flags_d = op_set_flags_in;
                    bs_upd_d    = op_bs_upd_in;
                    bs_carry_d  = op_bs_carry_in;
                    state_d     = S_ISSUE_LO;
                end
            end
            S_ISSUE_LO: begin
                if (cond_pass(cond_q, flags_q)) begin
                    alu_issue_out    = 1'b1;
                    alu_a_out        = a_q[DATA_W-1:0];
                    alu_b_out        = b_q[DATA_W-1:0];
                    alu_ctrl_out     = ctrl_q;
                    alu_carry_out    = carry_q;
                    alu_clz_out      = clz_q;
                    alu_bs_upd_out   = bs_upd_q;
                    alu_bs_carry_out = bs_carry_q;
                    skipped_d        = 1'b0;
                    state_d          = long_q ? S_ISSUE_HI : S_CAPTURE;
                end else begin
                    skipped_d = 1'b1;
                    res_d     = '0;
                    state_d   = S_DONE;
                end
            end
            // Low-pass result arrives now; its carry-out chains into the high pass
            S_ISSUE_HI: begin
                lo_d          = alu_result_in;
                z_lo_d        = alu_flags_in[FLAG_Z];
                alu_issue_out = 1'b1;
                alu_a_out     = a_q[RES_W-1:DATA_W];
                alu_b_out     = b_q[RES_W-1:DATA_W];
                alu_ctrl_out  = ctrl_q;
                alu_carry_out = alu_flags_in[FLAG_C];
                state_d       = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (long_q) begin
                    res_d     = {alu_result_in, lo_q};
                    new_flags = {alu_flags_in[3], z_lo_q & alu_flags_in[FLAG_Z], alu_flags_in[1:0]};
                end else begin
                    res_d     = {{DATA_W{1'b0}}, alu_result_in};
                end
                if (set_flags_q) begin
                    flags_d = new_flags;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                res_valid_out = 1'b1;
                if (res_ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            cond_q      <= '0;
            long_q      <= 1'b0;
            carry_q     <= 1'b0;
            clz_q       <= 1'b0;
            set_flags_q <= 1'b0;
            bs_upd_q    <= 1'b0;
            bs_carry_q  <= 1'b0;
            lo_q        <= '0;
            z_lo_q      <= 1'b0;
            res_q       <= '0;
            skipped_q   <= 1'b0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            cond_q      <= cond_d;
            long_q      <= long_d;
            carry_q     <= carry_d;
            clz_q       <= clz_d;
            set_flags_q <= set_flags_d;
            bs_upd_q    <= bs_upd_d;
            bs_carry_q  <= bs_carry_d;
            lo_q        <= lo_d;
            z_lo_q      <= z_lo_d;
            res_q       <= res_d;
            skipped_q   <= skipped_d;
            flags_q     <= flags_d;
        end
    end

    assign res_out         = res_q;
    assign res_skipped_out = skipped_q;
    assign flags_out       = flags_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a registered ADD/SUB alu_stage stand-in plus a
// transaction-level model (whole 64-bit arithmetic, latency timeline) checked every cycle.
module tb_alu_op_sequencer;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam logic [3:0] ADD = 4'h4, SUB = 4'h2;
    localparam logic [3:0] EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3, MI = 4'h4, PL = 4'h5;
    localparam logic [3:0] VC = 4'h7, HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB, GT = 4'hC;
    localparam logic [3:0] AL = 4'hE, NV = 4'hF;

    logic                clk_in;
    logic                reset_in;
    logic                op_valid_in, op_ready_out;
    logic [CTRL_W-1:0]   op_ctrl_in;
    logic [2*DATA_W-1:0] op_a_in, op_b_in;
    logic                op_long_in, op_carry_in, op_clz_in;
    logic [3:0]          op_cond_in;
    logic                op_set_flags_in, op_bs_upd_in, op_bs_carry_in;
    logic                alu_issue_out;
    logic [DATA_W-1:0]   alu_a_out, alu_b_out;
    logic [CTRL_W-1:0]   alu_ctrl_out;
    logic                alu_carry_out, alu_clz_out, alu_bs_upd_out, alu_bs_carry_out;
    logic [DATA_W-1:0]   alu_result_in;
    logic [3:0]          alu_flags_in;
    logic                res_valid_out, res_ready_in;
    logic [2*DATA_W-1:0] res_out;
    logic                res_skipped_out;
    logic [3:0]          flags_out;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic        m_busy, m_pass, m_long, m_setf, m_skip, m_acc;
    int          m_phase, m_lat;
    logic [63:0] m_a, m_b, m_res;
    logic [3:0]  m_ctrl, m_flags, m_newflags;
    logic        m_cin, m_hi_cin, m_clz, m_bsu, m_bsc;

    alu_op_sequencer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .op_valid_in(op_valid_in), .op_ready_out(op_ready_out), .op_ctrl_in(op_ctrl_in),
        .op_a_in(op_a_in), .op_b_in(op_b_in), .op_long_in(op_long_in), .op_carry_in(op_carry_in),
        .op_clz_in(op_clz_in), .op_cond_in(op_cond_in), .op_set_flags_in(op_set_flags_in),
        .op_bs_upd_in(op_bs_upd_in), .op_bs_carry_in(op_bs_carry_in),
        .alu_issue_out(alu_issue_out), .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
        .alu_ctrl_out(alu_ctrl_out), .alu_carry_out(alu_carry_out), .alu_clz_out(alu_clz_out),
        .alu_bs_upd_out(alu_bs_upd_out), .alu_bs_carry_out(alu_bs_carry_out),
        .alu_result_in(alu_result_in), .alu_flags_in(alu_flags_in),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in), .res_out(res_out),
        .res_skipped_out(res_skipped_out), .flags_out(flags_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [35:0] mock_alu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] ctrl, input logic cin,
                                             input logic bsu, input logic bsc);
        logic [31:0] bb;
        logic [32:0] s;
        bb = (ctrl == SUB) ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + 33'(cin);
        return {s[31], (s[31:0] == 32'd0), (bsu ? bsc : s[32]),
                ((a[31] == bb[31]) && (s[31] != a[31])), s[31:0]};
    endfunction

    // alu_stage stand-in: result and flags registered one cycle after issue
    always @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            alu_result_in <= '0;
            alu_flags_in  <= '0;
        end else if (alu_issue_out) begin
            {alu_flags_in, alu_result_in} <= mock_alu(alu_a_out, alu_b_out, alu_ctrl_out,
                                                      alu_carry_out, alu_bs_upd_out, alu_bs_carry_out);
        end
    end

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        if (cond == 4'hE) return 1'b1;
        return base ^ cond[0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-op outcome computed from the op's inputs at acceptance
    task automatic model_accept();
        logic [63:0] a, b, bb;
        logic [64:0] s;
        logic [32:0] slo;
        m_busy = 1'b1;
        m_phase = 1;
        m_pass = cond_holds(op_cond_in, m_flags);
        m_long = op_long_in;
        m_setf = op_set_flags_in;
        m_ctrl = op_ctrl_in;
        m_cin  = op_carry_in;
        m_clz  = op_clz_in;
        m_bsu  = op_bs_upd_in;
        m_bsc  = op_bs_carry_in;
        m_a    = op_a_in;
        m_b    = op_b_in;
        a  = op_long_in ? op_a_in : {32'd0, op_a_in[31:0]};
        b  = op_long_in ? op_b_in : {32'd0, op_b_in[31:0]};
        bb = (op_ctrl_in == SUB) ? ~b : b;
        slo = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + 33'(op_carry_in);
        m_hi_cin = slo[32];
        if (op_long_in) begin
            s = {1'b0, a} + {1'b0, bb} + 65'(op_carry_in);
            m_res = s[63:0];
            m_newflags = {s[63], (s[63:0] == 64'd0), s[64], ((a[63] == bb[63]) && (s[63] != a[63]))};
        end else begin
            m_res = {32'd0, slo[31:0]};
            m_newflags = {slo[31], (slo[31:0] == 32'd0), (op_bs_upd_in ? op_bs_carry_in : slo[32]),
                          ((a[31] == bb[31]) && (slo[31] != a[31]))};
        end
        m_skip = !m_pass;
        if (!m_pass) m_res = 64'd0;
        m_lat = !m_pass ? 2 : (op_long_in ? 4 : 3);
    endtask

    task automatic compare();
        logic v_exp, iss, hi;
        v_exp = m_busy && (m_phase >= m_lat);
        iss   = m_busy && m_pass && ((m_phase == 1) || (m_long && (m_phase == 2)));
        hi    = iss && (m_phase == 2);
        if (reset_in) check("op_ready", 64'(op_ready_out), 64'(!m_busy));
        check("res_valid", 64'(res_valid_out), 64'(v_exp));
        if (v_exp) begin
            check("res_out", res_out, m_res);
            check("res_skipped", 64'(res_skipped_out), 64'(m_skip));
        end
        check("flags_out", 64'(flags_out), 64'(m_flags));
        check("alu_issue", 64'(alu_issue_out), 64'(iss));
        check("alu_a", 64'(alu_a_out), !iss ? 64'd0 : hi ? 64'(m_a[63:32]) : 64'(m_a[31:0]));
        check("alu_b", 64'(alu_b_out), !iss ? 64'd0 : hi ? 64'(m_b[63:32]) : 64'(m_b[31:0]));
        check("alu_ctrl", 64'(alu_ctrl_out), iss ? 64'(m_ctrl) : 64'd0);
        check("alu_carry", 64'(alu_carry_out), !iss ? 64'd0 : hi ? 64'(m_hi_cin) : 64'(m_cin));
        check("alu_clz", 64'(alu_clz_out), 64'(iss && !hi && m_clz));
        check("alu_bs_upd", 64'(alu_bs_upd_out), 64'(iss && !hi && m_bsu));
        if (!hi) check("alu_bs_carry", 64'(alu_bs_carry_out), 64'(iss && m_bsc));
    endtask

    // One clock: note handshakes, advance the model across the edge, compare at negedge
    task automatic tick();
        logic hs_op, hs_res;
        hs_op  = reset_in && op_valid_in && !m_busy;
        hs_res = reset_in && res_ready_in && m_busy && (m_phase >= m_lat);
        @(posedge clk_in);
        if (reset_in) begin
            if (hs_res) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                m_phase++;
                if ((m_phase == m_lat) && m_pass && m_setf) m_flags = m_newflags;
            end
            if (hs_op) begin
                model_accept();
                m_acc = 1'b1;
            end
        end
        @(negedge clk_in);
        compare();
    endtask

    task automatic send_op(input logic [3:0] cond, input logic [3:0] ctrl,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic lng, input logic cin, input logic setf,
                           input logic clz = 1'b0, input logic bsu = 1'b0, input logic bsc = 1'b0);
        op_cond_in = cond; op_ctrl_in = ctrl; op_a_in = a; op_b_in = b;
        op_long_in = lng; op_carry_in = cin; op_set_flags_in = setf;
        op_clz_in = clz; op_bs_upd_in = bsu; op_bs_carry_in = bsc;
        op_valid_in = 1'b1;
        m_acc = 1'b0;
        for (int i = 0; i < 20 && !m_acc; i++) tick();
        check("accept", 64'(m_acc), 64'd1);
        op_valid_in = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!res_valid_out && cycles < 20) begin
            tick();
            cycles++;
        end
        check("res_valid_timeout", 64'(res_valid_out), 64'd1);
    endtask

    int cyc;

    initial begin
        m_busy = 0; m_pass = 0; m_long = 0; m_setf = 0; m_skip = 0; m_acc = 0;
        m_phase = 0; m_lat = 3; m_a = 0; m_b = 0; m_res = 0; m_ctrl = 0;
        m_flags = 0; m_newflags = 0; m_cin = 0; m_hi_cin = 0; m_clz = 0; m_bsu = 0; m_bsc = 0;
        reset_in = 1'b0; op_valid_in = 1'b0; res_ready_in = 1'b1;
        op_ctrl_in = '0; op_a_in = '0; op_b_in = '0; op_long_in = 0; op_carry_in = 0;
        op_clz_in = 0; op_cond_in = AL; op_set_flags_in = 0; op_bs_upd_in = 0; op_bs_carry_in = 0;

        // reset state
        tick(); tick();
        check("rst_res_out", res_out, 64'd0);
        check("rst_skipped", 64'(res_skipped_out), 64'd0);
        reset_in = 1'b1;
        tick();

        // 1: single ADD, three-cycle latency
        send_op(AL, ADD, 64'd5, 64'd7, 0, 0, 1);
        wait_done(cyc);
        check("t1_latency", 64'(cyc), 64'd2);
        check("t1_res", res_out, 64'd12);
        check("t1_flags", 64'(flags_out), 64'd0);
        tick();

        // 2: long ADD, carry chains between passes
        send_op(AL, ADD, 64'h1_FFFF_FFFF, 64'd1, 1, 0, 1);
        tick();
        check("t2_hi_carry", 64'(alu_carry_out), 64'd1);
        wait_done(cyc);
        check("t2_latency", 64'(cyc), 64'd2);
        check("t2_res", res_out, 64'h2_0000_0000);
        check("t2_flags", 64'(flags_out), 64'd0);
        tick();

        // 3: SUB sets Z, then conditional execution
        send_op(AL, SUB, 64'd3, 64'd3, 0, 1, 1);
        wait_done(cyc);
        check("t3_sub_flags", 64'(flags_out), 64'b0110);
        tick();
        send_op(EQ, ADD, 64'd1, 64'd1, 0, 0, 0);
        wait_done(cyc);
        check("t3_eq_res", res_out, 64'd2);
        tick();
        send_op(NE, ADD, 64'd9, 64'd9, 0, 0, 1);
        wait_done(cyc);
        check("t3_ne_latency", 64'(cyc), 64'd1);
        check("t3_ne_skipped", 64'(res_skipped_out), 64'd1);
        check("t3_ne_flags", 64'(flags_out), 64'b0110);
        tick();
        send_op(HI, ADD, 64'd2, 64'd2, 0, 0, 1); wait_done(cyc); tick();
        send_op(LS, ADD, 64'd2, 64'd2, 0, 0, 0); wait_done(cyc); tick();
        send_op(CC, ADD, 64'd2, 64'd2, 0, 0, 1); wait_done(cyc); tick();
        send_op(NV, ADD, 64'd2, 64'd2, 0, 0, 1); wait_done(cyc);
        check("nv_skipped", 64'(res_skipped_out), 64'd1);
        tick();

        // 4: long Z is the AND of both halves
        send_op(AL, ADD, 64'h1_0000_0000, 64'd0, 1, 0, 1);
        wait_done(cyc);
        check("t4_res", res_out, 64'h1_0000_0000);
        check("t4_flags", 64'(flags_out), 64'd0);
        tick();

        // overflow, then signed/negative conditions
        send_op(AL, ADD, 64'h7FFF_FFFF, 64'd1, 0, 0, 1);
        wait_done(cyc);
        check("ovf_flags", 64'(flags_out), 64'b1001);
        tick();
        send_op(GE, ADD, 64'd4, 64'd5, 0, 0, 0); wait_done(cyc); tick();
        send_op(LT, ADD, 64'd4, 64'd5, 0, 0, 1); wait_done(cyc); tick();
        send_op(MI, SUB, 64'd10, 64'd4, 0, 1, 0); wait_done(cyc);
        check("mi_res", res_out, 64'd6);
        tick();
        send_op(VC, ADD, 64'd4, 64'd5, 0, 0, 1); wait_done(cyc); tick();
        send_op(GT, ADD, 64'd4, 64'd5, 0, 0, 0); wait_done(cyc); tick();

        // barrel-shifter carry replaces the adder carry; CLZ select passes through
        send_op(AL, ADD, 64'd1, 64'd1, 0, 0, 1, 0, 1, 1);
        wait_done(cyc);
        check("bs_flags", 64'(flags_out), 64'b0010);
        tick();
        send_op(CS, ADD, 64'd3, 64'd4, 0, 0, 0, 1); wait_done(cyc); tick();
        send_op(PL, ADD, 64'd3, 64'd4, 0, 1, 0); wait_done(cyc); tick();

        // long SUB with borrow across halves; then a long op that leaves flags alone
        send_op(AL, SUB, 64'h5_0000_0000, 64'd1, 1, 1, 1);
        wait_done(cyc);
        check("lsub_res", res_out, 64'h4_FFFF_FFFF);
        check("lsub_flags", 64'(flags_out), 64'b0010);
        tick();
        send_op(AL, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 0, 0);
        wait_done(cyc);
        check("lnos_flags", 64'(flags_out), 64'b0010);
        tick();

        // 5: writeback back-pressure while another op waits
        res_ready_in = 1'b0;
        send_op(AL, ADD, 64'd2, 64'd3, 0, 0, 0);
        wait_done(cyc);
        op_cond_in = AL; op_ctrl_in = ADD; op_a_in = 64'd20; op_b_in = 64'd22;
        op_long_in = 0; op_carry_in = 0; op_set_flags_in = 1; op_clz_in = 0; op_bs_upd_in = 0;
        op_valid_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t5_held_res", res_out, 64'd5);
        check("t5_ready_low", 64'(op_ready_out), 64'd0);
        res_ready_in = 1'b1;
        send_op(AL, ADD, 64'd20, 64'd22, 0, 0, 1);
        wait_done(cyc);
        check("t5_next_res", res_out, 64'd42);
        tick();

        // 6: reset while the high pass is in flight
        send_op(AL, SUB, 64'd3, 64'd3, 0, 1, 1);
        wait_done(cyc);
        tick();
        send_op(AL, ADD, 64'h3_0000_0001, 64'h1_0000_0001, 1, 0, 1);
        tick();
        check("t6_hi_issue", 64'(alu_issue_out), 64'd1);
        reset_in = 1'b0;
        m_busy = 1'b0;
        m_flags = 4'd0;
        #1;
        compare();
        check("t6_flags", 64'(flags_out), 64'd0);
        check("t6_issue", 64'(alu_issue_out), 64'd0);
        check("t6_valid", 64'(res_valid_out), 64'd0);
        @(negedge clk_in);
        tick();
        reset_in = 1'b1;
        tick();
        send_op(AL, ADD, 64'd10, 64'd20, 0, 0, 1);
        wait_done(cyc);
        check("t6_after_latency", 64'(cyc), 64'd2);
        check("t6_after_res", res_out, 64'd30);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
